// File: rtl/fetch_unit.sv
// fetch_unit: PC walker, single-outstanding imem requester and instruction buffer.
// Optional FETCH_STATS_EN adds the fetch_count pop counter port.

// Instruction buffer with flush; head entry read straight from the storage registers.
// Latency: a write is visible at rd_dat/rd_vld one cycle later.
// Backpressure: writer must respect count; write+read in the same cycle is legal when full.
module fetch_fifo #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_rdy & rd_vld;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_vld) - CW'(pop);
        end
    end
endmodule

// Fetch front end: walks the PC, one outstanding imem request, buffers words for decode.
// Latency: imem_ack to instr_valid is one cycle into an empty buffer.
// Backpressure: stops requesting once buffered + outstanding words reach DEPTH.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count
`endif
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   disc_addr;
    logic [CW-1:0] occ;
    logic [CW-1:0] occ_next;
    logic          push;
    logic          pop;

    assign push     = (state == REQ) & imem_ack & ~redirect;
    assign pop      = instr_valid & instr_ready;
    assign occ_next = occ + CW'(push) - CW'(pop);

    fetch_fifo #(.W(64), .DEPTH(DEPTH)) u_buf (
        .clk    (clk),
        .reset  (reset),
        .flush  (redirect),
        .wr_vld (push),
        .wr_dat ({imem_rdata, fetch_pc}),
        .rd_rdy (instr_ready),
        .rd_vld (instr_valid),
        .rd_dat ({instr, instr_pc}),
        .count  (occ)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!redirect && occ < DEPTH_C) state_nxt = REQ;
            REQ: begin
                if (redirect)      state_nxt = imem_ack ? REQ : DISCARD;
                else if (imem_ack) state_nxt = (occ_next < DEPTH_C) ? REQ : IDLE;
            end
            DISCARD: if (imem_ack) state_nxt = (redirect || occ_next < DEPTH_C) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A discarded request must keep presenting the address it was issued with.
    always_comb begin
        imem_req  = (state != IDLE);
        imem_addr = (state == DISCARD) ? disc_addr : fetch_pc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            disc_addr <= RESET_PC;
        end else begin
            if (redirect)  fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (push) fetch_pc <= fetch_pc + 32'd4;
            if (state == REQ && redirect && !imem_ack) disc_addr <= fetch_pc;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset)   fetch_count <= '0;
        else if (pop) fetch_count <= fetch_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: randomised memory latency, consumer stalls and redirects,
// checked by a scoreboard holding the architectural PC stream the consumer must see.
module tb_fetch_unit;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE582_1000;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory model: per-request latency, ack only while a request is held.
    int   fixed_lat = 0;
    bit   force_ack = 1'b0;
    int   ack_cnt   = 0;
    initial begin
        int          lat;
        int          wait_cnt;
        logic        req_prev;
        logic        ack_prev;
        logic [31:0] addr_prev;
        logic        new_req;
        lat = 0; wait_cnt = 0; req_prev = 1'b0; ack_prev = 1'b0; addr_prev = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        forever begin
            cycle();
            new_req = imem_req && (!req_prev || ack_prev);
            if (imem_req && !new_req) chk("addr_stable", imem_addr, addr_prev);
            if (new_req) begin
                lat      = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                wait_cnt = 0;
            end
            if (force_ack)                        imem_ack = 1'b1;
            else if (imem_req && wait_cnt >= lat) imem_ack = 1'b1;
            else                                  imem_ack = 1'b0;
            if (imem_req) wait_cnt++;
            if (imem_req && imem_ack) ack_cnt++;
            imem_rdata = (imem_req && imem_ack) ? mem_word(imem_addr) : $urandom;
            req_prev  = imem_req;
            ack_prev  = imem_req && imem_ack;
            addr_prev = imem_addr;
        end
    end

    // Reference: the consumer sees consecutive words from the last fetch target.
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    int          n_pop  = 0;
    bit          mon_en = 1'b0;

    task automatic load_exp(input logic [31:0] start);
        exp_q.delete();
        model_pc = start;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(model_pc);
            model_pc = model_pc + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && reset && instr_valid && instr_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: got pc %h, expected no output", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", instr_pc, e);
                    chk("sb_instr", instr, mem_word(e));
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) cycle();
        load_exp(RESET_PC);
        n_pop   = 0;
        ack_cnt = 0;
        reset   = 1'b1;
    endtask

    // Redirect lasts one cycle; afterwards the buffer must be empty.
    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        cycle();
        redirect = 1'b0;
        load_exp(target & 32'hFFFF_FFFC);
        @(negedge clk);
        chk("no_stale_valid", instr_valid, 0);
    endtask

    initial begin
        bit          got;
        logic [31:0] tgt;
        reset = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        force_ack = 1'b1; fixed_lat = 0;
        load_exp(RESET_PC);
        mon_en = 1'b1;

        for (int i = 0; i < 3; i++) begin
            cycle();
            @(negedge clk);
            chk("rst_req", imem_req, 0);
            chk("rst_addr", imem_addr, RESET_PC);
            chk("rst_valid", instr_valid, 0);
        end
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
`ifdef FETCH_STATS_EN
        chk("rst_fetch_count", fetch_count, 0);
`endif

        // Release, then zero-wait streaming.
        cycle();
        reset = 1'b1; force_ack = 1'b0; n_pop = 0; ack_cnt = 0;
        @(negedge clk);
        chk("rel_req_low", imem_req, 0);
        cycle(); @(negedge clk);
        chk("rel_req", imem_req, 1);
        chk("rel_addr", imem_addr, RESET_PC);
        for (int k = 0; k < 4; k++) begin
            cycle(); @(negedge clk);
            chk("stream_valid", instr_valid, 1);
            chk("stream_pc", instr_pc, RESET_PC + 32'(4 * k));
        end

        // Backpressure from a fresh start.
        instr_ready = 1'b0;
        apply_reset();
        repeat (6) cycle();
        @(negedge clk);
        chk("bp_acks", 32'(ack_cnt), DEPTH);
        chk("bp_req_off", imem_req, 0);
        chk("bp_valid", instr_valid, 1);
        chk("bp_hold_pc", instr_pc, 0);
        chk("bp_hold_instr", instr, mem_word(0));
        cycle();
        instr_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) begin got = 1'b1; break; end
            cycle();
        end
        chk("bp_resume_req", got, 1);
        chk("bp_resume_addr", imem_addr, 32'd8);

        // Redirect while a slow request is outstanding.
        fixed_lat = 3;
        apply_reset();
        cycle();
        cycle();
        do_redirect(32'h0000_0101);
        chk("disc_req", imem_req, 1);
        chk("disc_old_addr", imem_addr, 0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack_cnt > 0) begin got = 1'b1; break; end
            cycle();
        end
        chk("disc_ack_seen", got, 1);
        cycle(); @(negedge clk);
        chk("disc_new_req", imem_req, 1);
        chk("disc_new_addr", imem_addr, 32'h0000_0100);
        chk("disc_empty", instr_valid, 0);
        repeat (12) cycle();
        chk("disc_progress", 32'(n_pop > 0), 1);

        // Redirect coinciding with an ack and a pop.
        fixed_lat = 0;
        repeat (10) cycle();
        @(negedge clk);
        chk("coin_pre_valid", instr_valid, 1);
        cycle();
        do_redirect(32'h0000_0200);
        chk("coin_req", imem_req, 1);
        chk("coin_addr", imem_addr, 32'h0000_0200);
`ifdef FETCH_STATS_EN
        chk("coin_fetch_count", fetch_count, 32'(n_pop));
`endif

        // Wrap of the fetch PC.
        cycle();
        do_redirect(32'hFFFF_FFFC);
        cycle(); @(negedge clk);
        chk("wrap_valid0", instr_valid, 1);
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
        cycle(); @(negedge clk);
        chk("wrap_valid1", instr_valid, 1);
        chk("wrap_pc1", instr_pc, 32'h0000_0000);

        // Random traffic.
        fixed_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            instr_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 24) == 0) begin
                tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                  : $urandom;
                do_redirect(tgt);
            end
        end
        @(negedge clk);
        chk("rand_progress", 32'(n_pop > 200), 1);
`ifdef FETCH_STATS_EN
        chk("rand_fetch_count", fetch_count, 32'(n_pop));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
